// File: rtl/vga_timing_pkg.sv
// Shared defaults for the VGA timing generator (640x480@60 at a 4:1 pixel clock divide)
// plus a small window-membership helper used for sync decoding.
package vga_timing_pkg;

    localparam int   DEF_H_ACTIVE = 640;
    localparam int   DEF_H_FP     = 16;
    localparam int   DEF_H_SYNC   = 96;
    localparam int   DEF_H_BP     = 48;
    localparam int   DEF_V_ACTIVE = 480;
    localparam int   DEF_V_FP     = 10;
    localparam int   DEF_V_SYNC   = 2;
    localparam int   DEF_V_BP     = 33;
    localparam logic DEF_HS_POL   = 1'b0;
    localparam logic DEF_VS_POL   = 1'b0;
    localparam int   DEF_CLK_DIV  = 4;
    localparam int   DEF_CNT_W    = 10;
    localparam int   DEF_COLOR_W  = 4;

    function automatic logic in_window(input int pos, input int lo, input int len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: counts 0..TOTAL-1 on en, flagging the enabled step that wraps to 0.
module vga_axis_counter #(
    parameter int TOTAL = 800,
    parameter int W     = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] cnt,
    output logic         wrap
);

    localparam logic [W-1:0] LAST = W'(TOTAL - 1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count and wrap strobe
    always_comb begin
        cnt_d = cnt_q;
        wrap  = 1'b0;
        if (en) begin
            if (cnt_q == LAST) begin
                cnt_d = {W{1'b0}};
                wrap  = 1'b1;
            end else begin
                cnt_d = cnt_q + W'(1);
            end
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= {W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: clock divider, h/v counters, a position stage (x/y/active/starts)
// and a one-pixel-later stage for sync and gated colour.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter logic HS_POL   = DEF_HS_POL,
    parameter logic VS_POL   = DEF_VS_POL,
    parameter int   CLK_DIV  = DEF_CLK_DIV,
    parameter int   CNT_W    = DEF_CNT_W,
    parameter int   COLOR_W  = DEF_COLOR_W
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3*COLOR_W-1:0] rgb_in,
    output logic                 pix_en,
    output logic [CNT_W-1:0]     x,
    output logic [CNT_W-1:0]     y,
    output logic                 active,
    output logic                 line_start,
    output logic                 frame_start,
    output logic                 hsync,
    output logic                 vsync,
    output logic [COLOR_W-1:0]   red,
    output logic [COLOR_W-1:0]   green,
    output logic [COLOR_W-1:0]   blue
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 1) begin : g_bad_clk_div
        $error("vga_timing_gen: CLK_DIV must be at least 1");
    end
    if (H_TOTAL > (1 << CNT_W)) begin : g_bad_h_total
        $error("vga_timing_gen: H_TOTAL does not fit in CNT_W bits");
    end
    if (V_TOTAL > (1 << CNT_W)) begin : g_bad_v_total
        $error("vga_timing_gen: V_TOTAL does not fit in CNT_W bits");
    end

    logic [DIV_W-1:0]   div_q, div_d;
    logic               pix_en_s;
    logic [CNT_W-1:0]   h_cnt_s, v_cnt_s;
    logic               h_wrap_s, v_wrap_s;
    logic               origin_q, origin_d;
    logic [CNT_W-1:0]   x_q, x_d, y_q, y_d;
    logic               active_q, active_d;
    logic               line_start_q, line_start_d;
    logic               frame_start_q, frame_start_d;
    logic               hsync_q, hsync_d, vsync_q, vsync_d;
    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;

    // Strobe is gated by reset so it reads 0 while reset is held, even with CLK_DIV=1
    assign pix_en_s = (div_q == DIV_LAST) && !reset;

    vga_axis_counter #(.TOTAL(H_TOTAL), .W(CNT_W)) u_h_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (pix_en_s),
        .cnt   (h_cnt_s),
        .wrap  (h_wrap_s)
    );

    vga_axis_counter #(.TOTAL(V_TOTAL), .W(CNT_W)) u_v_cnt (
        .clk   (clk),
        .reset (reset),
        .en    (h_wrap_s),
        .cnt   (v_cnt_s),
        .wrap  (v_wrap_s)
    );

    // Next state for divider, position stage and sync/colour stage
    always_comb begin
        div_d         = (div_q == DIV_LAST) ? {DIV_W{1'b0}} : div_q + DIV_W'(1);
        origin_d      = origin_q;
        x_d           = x_q;
        y_d           = y_q;
        active_d      = active_q;
        line_start_d  = 1'b0;
        frame_start_d = 1'b0;
        hsync_d       = hsync_q;
        vsync_d       = vsync_q;
        red_d         = red_q;
        green_d       = green_q;
        blue_d        = blue_q;
        if (pix_en_s) begin
            // origin_q marks that the counters sit at (0,0): after reset or a frame wrap
            origin_d      = v_wrap_s;
            x_d           = h_cnt_s;
            y_d           = v_cnt_s;
            active_d      = (h_cnt_s < CNT_W'(H_ACTIVE)) && (v_cnt_s < CNT_W'(V_ACTIVE));
            line_start_d  = (h_cnt_s == {CNT_W{1'b0}});
            frame_start_d = origin_q;
            hsync_d       = in_window(int'(x_q), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
            vsync_d       = in_window(int'(y_q), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
            if (active_q) begin
                red_d   = rgb_in[3*COLOR_W-1 -: COLOR_W];
                green_d = rgb_in[2*COLOR_W-1 -: COLOR_W];
                blue_d  = rgb_in[COLOR_W-1 -: COLOR_W];
            end else begin
                red_d   = {COLOR_W{1'b0}};
                green_d = {COLOR_W{1'b0}};
                blue_d  = {COLOR_W{1'b0}};
            end
        end else begin
            origin_d = origin_q;
        end
    end

    // State registers; reset wins immediately, abandoning any partial line
    always_ff @(posedge clk) begin
        if (reset) begin
            div_q         <= {DIV_W{1'b0}};
            origin_q      <= 1'b1;
            x_q           <= {CNT_W{1'b0}};
            y_q           <= {CNT_W{1'b0}};
            active_q      <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            hsync_q       <= ~HS_POL;
            vsync_q       <= ~VS_POL;
            red_q         <= {COLOR_W{1'b0}};
            green_q       <= {COLOR_W{1'b0}};
            blue_q        <= {COLOR_W{1'b0}};
        end else begin
            div_q         <= div_d;
            origin_q      <= origin_d;
            x_q           <= x_d;
            y_q           <= y_d;
            active_q      <= active_d;
            line_start_q  <= line_start_d;
            frame_start_q <= frame_start_d;
            hsync_q       <= hsync_d;
            vsync_q       <= vsync_d;
            red_q         <= red_d;
            green_q       <= green_d;
            blue_q        <= blue_d;
        end
    end

    assign pix_en      = pix_en_s;
    assign x           = x_q;
    assign y           = y_q;
    assign active      = active_q;
    assign line_start  = line_start_q;
    assign frame_start = frame_start_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign red         = red_q;
    assign green       = green_q;
    assign blue        = blue_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench: two small-timing instances (CLK_DIV=3 and CLK_DIV=1) share reset and
// rgb_in; expected outputs come from a closed-form raster model, checked every cycle.
module tb_vga_timing_gen;

    localparam int HA = 8, HFP = 2, HSY = 2, HBP = 2;
    localparam int VA = 4, VFP = 1, VSY = 1, VBP = 1;
    localparam int HT = HA + HFP + HSY + HBP;   // 14
    localparam int VT = VA + VFP + VSY + VBP;   // 7
    localparam int D0 = 3;
    localparam int D1 = 1;
    localparam int FRAME0 = HT * VT * D0;       // 294
    localparam int FRAME1 = HT * VT * D1;       // 98
    localparam int N_STEPS = 780;
    localparam int RST_AT  = 400;

    typedef struct packed {
        logic        pix;
        logic [3:0]  x;
        logic [3:0]  y;
        logic        act;
        logic        ls;
        logic        fs;
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } obs_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [11:0] rgb_in;

    logic       d0_pix, d0_act, d0_ls, d0_fs, d0_hs, d0_vs;
    logic [3:0] d0_x, d0_y, d0_r, d0_g, d0_b;
    logic       d1_pix, d1_act, d1_ls, d1_fs, d1_hs, d1_vs;
    logic [3:0] d1_x, d1_y, d1_r, d1_g, d1_b;

    obs_t q0[$];
    obs_t q1[$];
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b0), .VS_POL(1'b1), .CLK_DIV(D0), .CNT_W(4), .COLOR_W(4)
    ) dut0 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .pix_en(d0_pix),
        .x(d0_x), .y(d0_y), .active(d0_act), .line_start(d0_ls), .frame_start(d0_fs),
        .hsync(d0_hs), .vsync(d0_vs), .red(d0_r), .green(d0_g), .blue(d0_b)
    );

    vga_timing_gen #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
        .HS_POL(1'b1), .VS_POL(1'b0), .CLK_DIV(D1), .CNT_W(4), .COLOR_W(4)
    ) dut1 (
        .clk(clk), .reset(reset), .rgb_in(rgb_in), .pix_en(d1_pix),
        .x(d1_x), .y(d1_y), .active(d1_act), .line_start(d1_ls), .frame_start(d1_fs),
        .hsync(d1_hs), .vsync(d1_vs), .red(d1_r), .green(d1_g), .blue(d1_b)
    );

    // Expected outputs in a cycle where e non-reset edges have passed since the last reset
    // edge; rl is the rgb_in value captured at the most recent pixel edge.
    function automatic obs_t model(input int e, input bit rst, input int d,
                                   input bit hp, input bit vp, input logic [11:0] rl);
        obs_t o;
        int   p, k, xx, yy;
        o     = '0;
        p     = e / d;
        o.pix = !rst && (e % d == d - 1);
        o.hs  = !hp;
        o.vs  = !vp;
        if (p >= 1) begin
            k     = p - 1;
            xx    = k % HT;
            yy    = (k / HT) % VT;
            o.x   = 4'(xx);
            o.y   = 4'(yy);
            o.act = (xx < HA) && (yy < VA);
            o.ls  = (e % d == 0) && (xx == 0);
            o.fs  = o.ls && (yy == 0);
        end
        if (p >= 2) begin
            k  = p - 2;
            xx = k % HT;
            yy = (k / HT) % VT;
            if (xx >= HA + HFP && xx <= HA + HFP + HSY - 1) o.hs = hp;
            if (yy >= VA + VFP && yy <= VA + VFP + VSY - 1) o.vs = vp;
            if ((xx < HA) && (yy < VA)) o.rgb = rl;
        end
        return o;
    endfunction

    // Stimulus: reset, >1 frame, 1-clk mid-frame reset, >1 frame; junk rgb between strobes
    initial begin
        logic [11:0] tbl [8];
        logic [11:0] hist0 [int];
        logic [11:0] hist1 [int];
        logic [11:0] rgb_now, rl0, rl1;
        int          e0, e1;
        bit          rst_now, pix0;
        tbl[0] = 12'hFFF; tbl[1] = 12'h000; tbl[2] = 12'h123; tbl[3] = 12'hA5C;
        tbl[4] = 12'hF00; tbl[5] = 12'h0F0; tbl[6] = 12'h00F; tbl[7] = 12'h7E1;
        reset  = 1'b1;
        rgb_in = 12'h000;
        e0 = 0;
        e1 = 0;
        for (int s = 0; s < N_STEPS; s++) begin
            @(posedge clk);
            #1;
            rst_now = (s < 3) || (s == RST_AT);
            pix0    = !rst_now && (e0 % D0 == D0 - 1);
            rgb_now = pix0 ? tbl[(e0 / D0) % 8] : ~tbl[s % 8];
            reset   = rst_now;
            rgb_in  = rgb_now;
            rl0 = (e0 / D0 >= 1) ? hist0[e0 / D0 - 1] : 12'h000;
            rl1 = (e1 / D1 >= 1) ? hist1[e1 / D1 - 1] : 12'h000;
            q0.push_back(model(e0, rst_now, D0, 1'b0, 1'b1, rl0));
            q1.push_back(model(e1, rst_now, D1, 1'b1, 1'b0, rl1));
            if (rst_now) begin
                e0 = 0;
                e1 = 0;
            end else begin
                if (pix0) hist0[e0 / D0] = rgb_now;
                hist1[e1] = rgb_now;
                e0++;
                e1++;
            end
        end
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Monitor for dut0: per-cycle scoreboard plus frame_start period
    initial begin
        obs_t exp_o, got_o;
        int   cyc, last;
        cyc  = 0;
        last = -1;
        forever begin
            @(negedge clk);
            if (q0.size() > 0) begin
                exp_o = q0.pop_front();
                got_o = {d0_pix, d0_x, d0_y, d0_act, d0_ls, d0_fs, d0_hs, d0_vs, d0_r, d0_g, d0_b};
                n_cmp++;
                if (got_o !== exp_o) begin
                    n_err++;
                    $display("FAIL dut0_outputs t=%0t got=%h expected=%h", $time, got_o, exp_o);
                end
            end
            if (reset) begin
                last = -1;
            end else if (d0_fs) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != FRAME0) begin
                        n_err++;
                        $display("FAIL dut0_frame_period got=%0d expected=%0d", cyc - last, FRAME0);
                    end
                end
                last = cyc;
            end
            cyc++;
        end
    end

    // Monitor for dut1: per-cycle scoreboard plus frame_start period
    initial begin
        obs_t exp_o, got_o;
        int   cyc, last;
        cyc  = 0;
        last = -1;
        forever begin
            @(negedge clk);
            if (q1.size() > 0) begin
                exp_o = q1.pop_front();
                got_o = {d1_pix, d1_x, d1_y, d1_act, d1_ls, d1_fs, d1_hs, d1_vs, d1_r, d1_g, d1_b};
                n_cmp++;
                if (got_o !== exp_o) begin
                    n_err++;
                    $display("FAIL dut1_outputs t=%0t got=%h expected=%h", $time, got_o, exp_o);
                end
            end
            if (reset) begin
                last = -1;
            end else if (d1_fs) begin
                if (last >= 0) begin
                    n_cmp++;
                    if (cyc - last != FRAME1) begin
                        n_err++;
                        $display("FAIL dut1_frame_period got=%0d expected=%0d", cyc - last, FRAME1);
                    end
                end
                last = cyc;
            end
            cyc++;
        end
    end

endmodule
